// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Accepts a packed DIGITS-wide BCD word and returns its unsigned binary value
// BIN_W+1 cycles later. Any digit >9 flags err and forces bin_out to zero.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      s_q, s_d;
    logic [BIN_W-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inv_q, inv_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               bcd_bad;
    logic [SW-1:0]      s_sh;
    logic [SW-1:0]      s_step;
    logic [BIN_W-1:0]   b_step;

    // Flag any digit of the incoming word that is 10..15 (bit3 set with bit2 or bit1).
    always_comb begin
        bcd_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d+3] && (bcd_in[4*d+2] || bcd_in[4*d+1]))
                bcd_bad = 1'b1;
        end
    end

    // One reverse double-dabble iteration: shift {S,B} right, then fix up digits >=8.
    always_comb begin
        s_sh   = {1'b0, s_q[SW-1:1]};
        b_step = {s_q[0], b_q[BIN_W-1:1]};
        s_step = s_sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (s_sh[4*d+3])
                s_step[4*d +: 4] = s_sh[4*d +: 4] - 4'd3;
        end
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence and its outputs.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        bin_d   = bin_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    s_d     = bcd_in;
                    b_d     = '0;
                    inv_d   = bcd_bad;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                s_d = s_step;
                b_d = b_step;
                if (cnt_q == '0) begin
                    // Last iteration: publish the result as we enter DONE.
                    state_d = DONE;
                    done_d  = 1'b1;
                    bin_d   = inv_q ? '0 : b_step;
                    err_d   = inv_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: default (4-digit) instance plus a 2-digit instance.
module tb_bcd_to_bin_seq;

    typedef struct {
        int bin;
        bit err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start1 = 1'b0;
    logic [15:0] bcd1 = '0;
    logic        busy1, done1, err1;
    logic [13:0] bin1;

    logic        start2 = 1'b0;
    logic [7:0]  bcd2 = '0;
    logic        busy2, done2, err2;
    logic [6:0]  bin2;

    exp_t q1[$];
    exp_t q2[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bcd_to_bin_seq u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .bcd_in(bcd1),
        .busy(busy1), .done(done1), .bin_out(bin1), .err(err1)
    );

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .bcd_in(bcd2),
        .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitors: pop expected result whenever a done pulse is seen.
    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut1_unexpected_done: got done with bin_out %0d, expected no done", bin1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_bin_out", int'(bin1), e.bin);
                chk("dut1_err", int'(err1), int'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut2_unexpected_done: got done with bin_out %0d, expected no done", bin2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2_bin_out", int'(bin2), e.bin);
                chk("dut2_err", int'(err2), int'(e.err));
            end
        end
    end

    // Called at a negedge; leaves at the negedge right after the accepting edge.
    task automatic issue1(input logic [15:0] bcd, input int exp_bin, input bit exp_err);
        exp_t e;
        e.bin = exp_bin; e.err = exp_err;
        q1.push_back(e);
        bcd1 = bcd; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // Waits (bounded) for done1; k = negedges elapsed.
    task automatic wait_done1(output int k);
        k = 0;
        while (!done1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done1) begin
            n_tests++; n_fail++;
            $display("FAIL dut1_timeout: got no done after %0d cycles, expected done", k);
        end
    endtask

    task automatic wait_done2(output int k);
        k = 0;
        while (!done2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done2) begin
            n_tests++; n_fail++;
            $display("FAIL dut2_timeout: got no done after %0d cycles, expected done", k);
        end
    endtask

    initial begin
        int k;
        int last;
        exp_t e;

        // Reset state.
        #1;
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_done1", int'(done1), 0);
        chk("rst_bin1", int'(bin1), 0);
        chk("rst_err1", int'(err1), 0);
        chk("rst_busy2", int'(busy2), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: zero input; done appears 15 cycles after the start cycle.
        issue1(16'h0000, 0, 1'b0);
        wait_done1(k);
        chk("t1_latency", k + 1, 15);
        repeat (2) @(negedge clk);

        // 2: max value; busy high exactly 15 cycles.
        issue1(16'h9999, 9999, 1'b0);
        k = 0;
        while (busy1 && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk("t2_busy_cycles", k, 15);
        @(negedge clk);

        // 3: second start mid-job and bcd_in changes are ignored.
        issue1(16'h1234, 1234, 1'b0);
        bcd1 = 16'h8888;
        repeat (4) @(negedge clk);
        start1 = 1'b1; bcd1 = 16'h9999;
        @(negedge clk);
        start1 = 1'b0; bcd1 = 16'h7777;
        wait_done1(k);
        // Start during the DONE cycle must also be dropped.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("t3_busy_after_done_start", int'(busy1), 0);
        repeat (3) @(negedge clk);
        chk("t3_busy_idle", int'(busy1), 0);

        // 4: invalid digit, then a valid job.
        issue1(16'h12A4, 0, 1'b1);
        wait_done1(k);
        repeat (2) @(negedge clk);
        issue1(16'h0042, 42, 1'b0);
        wait_done1(k);
        repeat (2) @(negedge clk);

        // 5: reset mid-conversion aborts with no done pulse.
        q1.push_back('{bin: 5678, err: 1'b0});
        void'(q1.pop_back());  // job will be aborted: nothing expected
        bcd1 = 16'h5678; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_busy", int'(busy1), 0);
        chk("t5_done", int'(done1), 0);
        chk("t5_bin", int'(bin1), 0);
        chk("t5_err", int'(err1), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_no_done_busy", int'(busy1), 0);
        issue1(16'h0001, 1, 1'b0);
        wait_done1(k);
        repeat (2) @(negedge clk);

        // 6a: 2-digit instance, start held with 99 -> one result every 9 cycles.
        for (int j = 0; j < 4; j++) begin
            e.bin = 99; e.err = 1'b0;
            q2.push_back(e);
        end
        bcd2 = 8'h99; start2 = 1'b1;
        last = 0;
        for (int j = 0; j < 4; j++) begin
            wait_done2(k);
            if (j > 0) chk("t6_period", cyc - last, 9);
            last = cyc;
            if (j == 3) start2 = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // 6b: sweep 0..99 against the decimal value itself.
        for (int i = 0; i < 100; i++) begin
            e.bin = i; e.err = 1'b0;
            q2.push_back(e);
            bcd2 = {4'(i / 10), 4'(i % 10)};
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            wait_done2(k);
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
